// File: rtl/cache_data_array.sv
// Multi-way single-port L1 cache data array with per-word write masks, registered
// all-way reads and a post-reset sequencer that zeroes every line.
module cache_data_array #(
  parameter  int WAYS   = 2,
  parameter  int SETS   = 512,
  parameter  int LINE_W = 128,
  parameter  int WORD_W = 32,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int WORDS  = LINE_W / WORD_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  input  logic                     req_we_i,
  input  logic [IDX_W-1:0]         req_index_i,
  input  logic [WAY_W-1:0]         req_way_i,
  input  logic [WORDS-1:0]         req_wmask_i,
  input  logic [LINE_W-1:0]        wdata_i,
  output logic                     ready_o,
  output logic                     rvalid_o,
  output logic [WAYS*LINE_W-1:0]   rdata_o
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_r, state_nxt_s;
  logic [IDX_W-1:0]        cnt_r, cnt_nxt_s;
  logic                    ready_r, ready_nxt_s;
  logic                    rvalid_r;
  logic [WAYS*LINE_W-1:0]  rdata_r;
  logic [WAYS*LINE_W-1:0]  rd_line_s;
  logic                    acc_s;
  logic                    rd_acc_s;
  logic                    wr_en_s;
  logic                    wr_all_s;
  logic [IDX_W-1:0]        mem_idx_s;
  logic [WAY_W-1:0]        wr_way_s;
  logic [WORDS-1:0]        wr_mask_s;
  logic [LINE_W-1:0]       wr_data_s;

  assign acc_s    = req_valid_i & ready_r & ~rst_i;
  assign rd_acc_s = acc_s & ~req_we_i;

  // Next-state logic: INIT walks every index once, then the array stays in RUN
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ready_nxt_s = ready_r;
    case (state_r)
      ST_INIT: begin
        cnt_nxt_s = cnt_r + IDX_W'(1);
        if (cnt_r == IDX_W'(SETS - 1)) begin
          state_nxt_s = ST_RUN;
          ready_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_INIT;
          ready_nxt_s = 1'b0;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
        ready_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s = ST_INIT;
        cnt_nxt_s   = {IDX_W{1'b0}};
        ready_nxt_s = 1'b0;
      end
    endcase
  end

  // Single shared port: the init sequencer owns it until the array is ready
  always_comb begin
    wr_en_s   = 1'b0;
    wr_all_s  = 1'b0;
    mem_idx_s = req_index_i;
    wr_way_s  = req_way_i;
    wr_mask_s = req_wmask_i;
    wr_data_s = wdata_i;
    if ((state_r == ST_INIT) && !rst_i) begin
      wr_en_s   = 1'b1;
      wr_all_s  = 1'b1;
      mem_idx_s = cnt_r;
      wr_mask_s = {WORDS{1'b1}};
      wr_data_s = {LINE_W{1'b0}};
    end else begin
      wr_en_s   = acc_s & req_we_i;
      wr_all_s  = 1'b0;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [LINE_W-1:0] mem_r [SETS];
    logic              way_we_s;

    // Out-of-range way numbers never match, so such writes drop out here
    assign way_we_s = wr_en_s & (wr_all_s | (wr_way_s == WAY_W'(w)));

    // Word-granular line write
    always_ff @(posedge clk_i) begin
      for (int k = 0; k < WORDS; k++) begin
        if (way_we_s && wr_mask_s[k]) begin
          mem_r[mem_idx_s][k*WORD_W +: WORD_W] <= wr_data_s[k*WORD_W +: WORD_W];
        end
      end
    end

    assign rd_line_s[w*LINE_W +: LINE_W] = mem_r[mem_idx_s];
  end

  // Control and read-result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_INIT;
      cnt_r    <= {IDX_W{1'b0}};
      ready_r  <= 1'b0;
      rvalid_r <= 1'b0;
      rdata_r  <= {(WAYS*LINE_W){1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      ready_r  <= ready_nxt_s;
      rvalid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rdata_r <= rd_line_s;
      end
    end
  end

  assign ready_o  = ready_r;
  assign rvalid_o = rvalid_r;
  assign rdata_o  = rdata_r;

endmodule

// File: tb/tb_cache_data_array.sv
// Randomised and directed bench for cache_data_array against an array-based
// reference model of the data store and its read/ready timing.
module tb_cache_data_array;

  localparam int WAYS   = 2;
  localparam int SETS   = 512;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int WORDS  = LINE_W / WORD_W;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   req_valid_i;
  logic                   req_we_i;
  logic [8:0]             req_index_i;
  logic [0:0]             req_way_i;
  logic [3:0]             req_wmask_i;
  logic [127:0]           wdata_i;
  logic                   ready_o;
  logic                   rvalid_o;
  logic [255:0]           rdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [LINE_W-1:0] m_mem [WAYS][SETS];
  logic              m_ready;
  int                m_left;
  logic              m_rvalid;
  logic [255:0]      m_rdata;

  cache_data_array #(.WAYS(WAYS), .SETS(SETS), .LINE_W(LINE_W), .WORD_W(WORD_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
    .req_index_i(req_index_i), .req_way_i(req_way_i), .req_wmask_i(req_wmask_i),
    .wdata_i(wdata_i), .ready_o(ready_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge to the model using the currently driven inputs
  task automatic model_edge();
    if (rst_i) begin
      m_ready  = 1'b0;
      m_left   = SETS;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) m_mem[w][s] = '0;
    end else begin
      m_rvalid = 1'b0;
      if (m_ready && req_valid_i) begin
        if (!req_we_i) begin
          for (int w = 0; w < WAYS; w++) m_rdata[w*LINE_W +: LINE_W] = m_mem[w][req_index_i];
          m_rvalid = 1'b1;
        end else if (int'(req_way_i) < WAYS) begin
          for (int k = 0; k < WORDS; k++)
            if (req_wmask_i[k]) m_mem[req_way_i][req_index_i][k*WORD_W +: WORD_W] = wdata_i[k*WORD_W +: WORD_W];
        end
      end
      if (!m_ready) begin
        m_left--;
        if (m_left == 0) m_ready = 1'b1;
      end
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [8:0] idx, input logic way,
                      input logic [3:0] mask, input logic [127:0] wd);
    req_valid_i = v;
    req_we_i    = we;
    req_index_i = idx;
    req_way_i   = way;
    req_wmask_i = mask;
    wdata_i     = wd;
    @(posedge clk_i);
    model_edge();
    #1;
    check_eq("ready", {255'd0, ready_o}, {255'd0, m_ready});
    check_eq("rvalid", {255'd0, rvalid_o}, {255'd0, m_rvalid});
    check_eq("rdata", rdata_o, m_rdata);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 9'd0, 1'b0, 4'd0, 128'd0);
  endtask

  task automatic rd(input logic [8:0] idx);
    step(1'b1, 1'b0, idx, 1'($urandom_range(0, 1)), 4'($urandom), 128'd0);
  endtask

  task automatic wr(input logic [8:0] idx, input logic way, input logic [3:0] mask, input logic [127:0] wd);
    step(1'b1, 1'b1, idx, way, mask, wd);
  endtask

  // Run through INIT with junk requests, returning how many cycles ready stayed low
  task automatic run_init(output int cycles);
    cycles = 0;
    while (!ready_o && cycles < 600) begin
      if (cycles[0]) step(1'b1, 1'b1, 9'd5, 1'($urandom_range(0, 1)), 4'hF, {128{1'b1}});
      else step(1'b1, 1'b0, 9'd5, 1'b0, 4'h0, 128'd0);
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    logic [8:0] idx_tab [8];
    idx_tab = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd5, 9'd7, 9'd510, 9'd511};

    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) idle();
    rst_i = 1'b0;

    run_init(cyc);
    check_eq("init_len", 256'(cyc), 256'd512);

    rd(9'd5);
    check_eq("init_ignored", rdata_o, 256'd0);

    wr(9'd7, 1'b1, 4'b0101, 128'h44444444_33333333_22222222_11111111);
    rd(9'd7);
    check_eq("mask_rvalid", {255'd0, rvalid_o}, 256'd1);
    check_eq("mask_way1", {128'd0, rdata_o[255:128]}, {128'd0, 128'h00000000_33333333_00000000_11111111});
    check_eq("mask_way0", {128'd0, rdata_o[127:0]}, 256'd0);

    wr(9'd7, 1'b1, 4'b1010, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    wr(9'd7, 1'b0, 4'b0000, {128{1'b1}});
    rd(9'd7);
    check_eq("merge_way1", {128'd0, rdata_o[255:128]}, {128'd0, 128'hDDDDDDDD_33333333_BBBBBBBB_11111111});

    wr(9'd511, 1'b0, 4'hF, 128'h0123_4567_89AB_CDEF_0000_1111_2222_CAFE);
    rd(9'd511);
    check_eq("b2b_way0", {128'd0, rdata_o[127:0]}, {128'd0, 128'h0123_4567_89AB_CDEF_0000_1111_2222_CAFE});
    rd(9'd0);
    check_eq("wrap_idx0", rdata_o, 256'd0);

    for (int i = 0; i < 4; i++) wr(9'(i), 1'(i), 4'hF, {4{32'(i * 16 + 3)}});
    for (int i = 0; i < 4; i++) begin
      rd(9'(i));
      check_eq("stream_rvalid", {255'd0, rvalid_o}, 256'd1);
    end
    idle();
    check_eq("idle_rvalid", {255'd0, rvalid_o}, 256'd0);
    check_eq("idle_hold", {128'd0, rdata_o[255:128]}, {128'd0, {4{32'd51}}});

    for (int i = 0; i < 400; i++) begin
      logic [8:0] idx;
      idx = idx_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) idle();
      else if ($urandom_range(0, 1) == 0) rd(idx);
      else wr(idx, 1'($urandom_range(0, 1)), 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
    end

    rd(9'd7);
    rst_i = 1'b1;
    rd(9'd7);
    check_eq("rst_rvalid", {255'd0, rvalid_o}, 256'd0);
    check_eq("rst_rdata", rdata_o, 256'd0);
    rst_i = 1'b0;
    run_init(cyc);
    check_eq("reinit_len", 256'(cyc), 256'd512);
    rd(9'd7);
    check_eq("reinit_zero", rdata_o, 256'd0);
    rd(9'd511);
    check_eq("reinit_zero_511", rdata_o, 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
